margin_sampling_sequencer: RTL and testbench
============================================

// Module: margin_sampling_sequencer
// PURPOSE
//  Multi-pass sequencer for the margin-sampling datapath. Replaces the fixed single-batch controller with an explicit FSM.
//  Runtime-configurable read length and pass count; handshakes with the margin tree (MTreeDone).
//  Honours write back-pressure on BRAM port B (WrReady); supports Abort.
//  Sits between the host start/ready interface and the BRAM-A / margin pipeline / margin tree / BRAM-B datapath.
// PARAMETERS
//  MAX_DATA_LENGTH  512   max samples read from BRAM A per pass
//  PIPE_DEPTH       3     margin pipeline latency; drain = PIPE_DEPTH+1 cycles
//  BATCH_SIZE       1024  results written to BRAM B per pass
//  N_BANKS          4     register banks; TrigMTree held N_BANKS cycles
//  MAX_PASSES       8     max passes per run
//  WE_WIDTH         4     byte-enable width of BRAM B
// PORTS
//  clk             in   1         clock
//  rst             in   1         synchronous reset, active-high
//  Start           in   1         run request; sampled only in IDLE
//  CfgLen          in   LW        samples per pass, LW=$clog2(MAX_DATA_LENGTH+1); latched on Start
//  CfgPasses       in   PW        pass count, PW=$clog2(MAX_PASSES+1); latched on Start
//  Abort           in   1         terminate run
//  MTreeDone       in   1         margin tree finished reduction
//  WrReady         in   1         BRAM B / downstream can accept a write
//  Ready           out  1         in IDLE
//  Busy            out  1         in READ/DRAIN/REDUCE/WRITE
//  Done            out  1         1-cycle pulse, run completed normally
//  CfgErr          out  1         1-cycle pulse, Start rejected
//  PassIdx         out  PW        current pass, 0-based
//  EnA             out  1         BRAM A read enable
//  AddrA           out  $clog2(MAX_DATA_LENGTH)                BRAM A address
//  MrgnPipelineEn  out  1         margin pipeline advance
//  CntIndxEn       out  1         index counter enable (valid at pipeline output)
//  TrigMTree       out  1         margin tree trigger
//  EnB             out  1         BRAM B enable
//  WeB             out  WE_WIDTH  BRAM B write enables
//  AddrB           out  $clog2(MAX_PASSES*BATCH_SIZE)          BRAM B address
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0 except Ready=1. Counters, PassIdx and delay line cleared.
//  - IDLE, Start=1:
//    - CfgLen==0, CfgLen>MAX_DATA_LENGTH or CfgPasses>MAX_PASSES -> CfgErr pulse next cycle; stay IDLE.
//    - Else latch config (CfgPasses==0 treated as 1) -> READ.
//  - READ (CfgLen cycles): EnA=1, MrgnPipelineEn=1, AddrA=0..CfgLen-1; AddrA restarts at 0 every pass.
//  - DRAIN (PIPE_DEPTH+1 cycles): EnA=0, MrgnPipelineEn=1.
//  - CntIndxEn = EnA delayed PIPE_DEPTH+1 cycles; it is exactly CfgLen cycles wide per pass.
//  - REDUCE: MrgnPipelineEn=0. TrigMTree=1 for the first N_BANKS cycles of REDUCE.
//  - MTreeDone is sampled from the first REDUCE cycle onward; MTreeDone=1 -> WRITE next cycle.
//  - WRITE: EnB=WrReady, WeB={WE_WIDTH{WrReady}}, AddrB=PassIdx*BATCH_SIZE+k.
//    - k advances only on WrReady=1; WrReady=0 freezes k and AddrB.
//    - After the BATCH_SIZE-th accepted write: PassIdx<passes-1 -> PassIdx+1, READ; else -> DONE.
//  - DONE: one cycle, Done=1, Busy=0, Ready=0 -> IDLE.
//  - Abort (any non-IDLE state) -> IDLE next cycle:
//    - All enables 0, delay line flushed.
//    - No Done pulse; PassIdx reset to 0.
//    - Abort has priority over every other transition.
//  - Start while not IDLE is ignored; Start and Abort together in IDLE: Abort wins, nothing starts.
//  - rst asserted mid-run: identical to reset, takes effect the next edge.
//  - All counters are sized for their maximum value; no wrap-around reachable within legal config.
// STRUCTURE
//  - Package ms_seq_pkg:
//    - phase enum (IDLE, READ, DRAIN, REDUCE, WRITE, DONE).
//    - Width localparams LW/PW/address widths derived from the parameters.
//  - Sub-module ms_valid_delay #(DEPTH): shift register with sync clear, used for CntIndxEn.
//  - Main FSM plus phase counter, write counter and pass counter in this module.
// TESTING (MAX_DATA_LENGTH=16, PIPE_DEPTH=3, BATCH_SIZE=8, N_BANKS=4, MAX_PASSES=4)
//  1 Nominal run. Start at cycle 0, CfgLen=10, CfgPasses=1, MTreeDone at cycle 20, WrReady=1.
//    - EnA cycles 1-10 (AddrA 0-9); CntIndxEn cycles 5-14; TrigMTree cycles 15-18.
//    - EnB cycles 21-28 (AddrB 0-7); Done at cycle 29; Ready at cycle 30.
//  2 Multi-pass. CfgPasses=3.
//    - Three READ bursts with AddrA starting at 0 each time.
//    - AddrB covers 0-23 contiguously; PassIdx steps 0,1,2; a single Done.
//  3 Back-pressure. WrReady low on the 3rd and 4th WRITE cycles.
//    - EnB/WeB are 0 and AddrB holds at 2 during the stall.
//    - Exactly 8 writes total; Done is delayed 2 cycles.
//  4 Abort. Abort in the DRAIN of pass 1.
//    - Next cycle: Ready=1, all enables 0, PassIdx=0, no Done.
//    - A new Start afterwards runs cleanly.
//  5 Config errors. CfgLen=0, then CfgLen=17.
//    - CfgErr pulses each time; state stays IDLE.
//    - Start during Busy has no effect.
//  6 Reset mid-WRITE. rst=1 for one cycle.
//    - All outputs return to reset values on that edge.
//    - No further EnB after the reset edge.

Source files
------------

// File: rtl/ms_seq_pkg.sv
// ms_seq_pkg: shared phase encoding and default sizing for the margin-sampling sequencer.
package ms_seq_pkg;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, REDUCE, WRITE, DONE} phase_e;

    localparam int DEF_MAX_DATA_LENGTH = 512;
    localparam int DEF_PIPE_DEPTH      = 3;
    localparam int DEF_BATCH_SIZE      = 1024;
    localparam int DEF_N_BANKS         = 4;
    localparam int DEF_MAX_PASSES      = 8;
    localparam int DEF_WE_WIDTH        = 4;

    localparam int DEF_LW   = $clog2(DEF_MAX_DATA_LENGTH + 1);
    localparam int DEF_PW   = $clog2(DEF_MAX_PASSES + 1);
    localparam int DEF_AW_A = $clog2(DEF_MAX_DATA_LENGTH);
    localparam int DEF_AW_B = $clog2(DEF_MAX_PASSES * DEF_BATCH_SIZE);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_valid_delay.sv
// ms_valid_delay: fixed-depth valid shift register with synchronous clear.
module ms_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) sr_q <= '0;
        else              sr_q <= (sr_q << 1) | DEPTH'(d_i);
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/margin_sampling_sequencer.sv
// margin_sampling_sequencer: multi-pass READ/DRAIN/REDUCE/WRITE controller for the margin datapath.
// Config is latched on Start; Abort returns to IDLE from any busy phase without a Done pulse.
module margin_sampling_sequencer
    import ms_seq_pkg::*;
#(
    parameter int MAX_DATA_LENGTH = DEF_MAX_DATA_LENGTH,
    parameter int PIPE_DEPTH      = DEF_PIPE_DEPTH,
    parameter int BATCH_SIZE      = DEF_BATCH_SIZE,
    parameter int N_BANKS         = DEF_N_BANKS,
    parameter int MAX_PASSES      = DEF_MAX_PASSES,
    parameter int WE_WIDTH        = DEF_WE_WIDTH,
    localparam int LW   = $clog2(MAX_DATA_LENGTH + 1),
    localparam int PW   = $clog2(MAX_PASSES + 1),
    localparam int AW_A = $clog2(MAX_DATA_LENGTH),
    localparam int AW_B = $clog2(MAX_PASSES * BATCH_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic [LW-1:0]       CfgLen,
    input  logic [PW-1:0]       CfgPasses,
    input  logic                Abort,
    input  logic                MTreeDone,
    input  logic                WrReady,
    output logic                Ready,
    output logic                Busy,
    output logic                Done,
    output logic                CfgErr,
    output logic [PW-1:0]       PassIdx,
    output logic                EnA,
    output logic [AW_A-1:0]     AddrA,
    output logic                MrgnPipelineEn,
    output logic                CntIndxEn,
    output logic                TrigMTree,
    output logic                EnB,
    output logic [WE_WIDTH-1:0] WeB,
    output logic [AW_B-1:0]     AddrB
);

    localparam int DRAIN_N = PIPE_DEPTH + 1;
    localparam int CW      = $clog2(max3(MAX_DATA_LENGTH, DRAIN_N, N_BANKS) + 1);
    localparam int KW      = $clog2(BATCH_SIZE + 1);

    phase_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [PW-1:0] passes_q, passes_d;
    logic [LW-1:0] len_q, len_d;
    logic          cfg_err_q, cfg_err_d;
    logic          cfg_bad, abort_run;

    assign cfg_bad   = (CfgLen == '0) || (CfgLen > LW'(MAX_DATA_LENGTH)) || (CfgPasses > PW'(MAX_PASSES));
    assign abort_run = Abort && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            pass_q    <= '0;
            passes_q  <= '0;
            len_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            pass_q    <= pass_d;
            passes_q  <= passes_d;
            len_q     <= len_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        pass_d    = pass_q;
        passes_d  = passes_q;
        len_d     = len_q;
        cfg_err_d = 1'b0;
        if (abort_run) begin
            state_d = IDLE;
            cnt_d   = '0;
            k_d     = '0;
            pass_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start && !Abort) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            len_d    = CfgLen;
                            passes_d = (CfgPasses == '0) ? PW'(1) : CfgPasses;
                            cnt_d    = '0;
                            k_d      = '0;
                            pass_d   = '0;
                            state_d  = READ;
                        end
                    end
                end
                READ: begin
                    cnt_d   = ((cnt_q + 1'b1) == CW'(len_q)) ? '0 : cnt_q + 1'b1;
                    state_d = ((cnt_q + 1'b1) == CW'(len_q)) ? DRAIN : READ;
                end
                DRAIN: begin
                    cnt_d   = (cnt_q == CW'(DRAIN_N - 1)) ? '0 : cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(DRAIN_N - 1)) ? REDUCE : DRAIN;
                end
                REDUCE: begin
                    // Counter saturates at N_BANKS; it only gates the trigger window.
                    if (MTreeDone) begin
                        cnt_d   = '0;
                        k_d     = '0;
                        state_d = WRITE;
                    end else if (cnt_q < CW'(N_BANKS)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (WrReady) begin
                        if (k_q == KW'(BATCH_SIZE - 1)) begin
                            k_d     = '0;
                            state_d = (pass_q == passes_q - 1'b1) ? DONE : READ;
                            pass_d  = (pass_q == passes_q - 1'b1) ? pass_q : pass_q + 1'b1;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    pass_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    ms_valid_delay #(.DEPTH(DRAIN_N)) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .clr_i (abort_run),
        .d_i   (EnA),
        .q_o   (CntIndxEn)
    );

    assign Ready          = (state_q == IDLE);
    assign Busy           = (state_q == READ) || (state_q == DRAIN) || (state_q == REDUCE) || (state_q == WRITE);
    assign Done           = (state_q == DONE);
    assign CfgErr         = cfg_err_q;
    assign PassIdx        = pass_q;
    assign EnA            = (state_q == READ);
    assign AddrA          = EnA ? cnt_q[AW_A-1:0] : '0;
    assign MrgnPipelineEn = (state_q == READ) || (state_q == DRAIN);
    assign TrigMTree      = (state_q == REDUCE) && (cnt_q < CW'(N_BANKS));
    assign EnB            = (state_q == WRITE) && WrReady;
    assign WeB            = {WE_WIDTH{EnB}};
    assign AddrB          = (state_q == WRITE) ? AW_B'(pass_q) * AW_B'(BATCH_SIZE) + AW_B'(k_q) : '0;

endmodule

// File: tb/tb_margin_sampling_sequencer.sv
// tb_margin_sampling_sequencer: schedule-based reference model; each run is expanded into per-cycle stimulus and expected outputs.
module tb_margin_sampling_sequencer;

    localparam int ML = 16, PD = 3, BS = 8, NB = 4, MP = 4, WW = 4;
    localparam int N = 1024;

    logic clk = 1'b0, rst = 1'b1;
    logic Start = 1'b0, Abort = 1'b0, MTreeDone = 1'b0, WrReady = 1'b0;
    logic [4:0] CfgLen = '0;
    logic [2:0] CfgPasses = '0;
    logic Ready, Busy, Done, CfgErr, EnA, MrgnPipelineEn, CntIndxEn, TrigMTree, EnB;
    logic [2:0] PassIdx;
    logic [3:0] AddrA, WeB;
    logic [4:0] AddrB;

    typedef struct {
        bit ready, busy, done, err;
        int pidx;
        bit ena;
        int addra;
        bit mpe, cie, trig, enb;
        int addrb;
    } ex_t;

    ex_t ex[N];
    ex_t idle_ex;
    bit st_start[N], st_abort[N], st_rst[N], st_mtd[N], st_rdy[N];
    logic [4:0] st_len[N];
    logic [2:0] st_pas[N];
    int n_cyc;
    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    margin_sampling_sequencer #(
        .MAX_DATA_LENGTH(ML), .PIPE_DEPTH(PD), .BATCH_SIZE(BS),
        .N_BANKS(NB), .MAX_PASSES(MP), .WE_WIDTH(WW)
    ) dut (
        .clk(clk), .rst(rst), .Start(Start), .CfgLen(CfgLen), .CfgPasses(CfgPasses),
        .Abort(Abort), .MTreeDone(MTreeDone), .WrReady(WrReady),
        .Ready(Ready), .Busy(Busy), .Done(Done), .CfgErr(CfgErr), .PassIdx(PassIdx),
        .EnA(EnA), .AddrA(AddrA), .MrgnPipelineEn(MrgnPipelineEn), .CntIndxEn(CntIndxEn),
        .TrigMTree(TrigMTree), .EnB(EnB), .WeB(WeB), .AddrB(AddrB)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] pk(input ex_t e);
        return {e.ready, e.busy, e.done, e.err, 3'(e.pidx), e.ena, 4'(e.addra),
                e.mpe, e.cie, e.trig, e.enb, {4{e.enb}}, 5'(e.addrb)};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {Ready, Busy, Done, CfgErr, PassIdx, EnA, AddrA,
                MrgnPipelineEn, CntIndxEn, TrigMTree, EnB, WeB, AddrB};
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            ex[i] = idle_ex;
            st_start[i] = 1'b0;
            st_abort[i] = 1'b0;
            st_rst[i]   = 1'b0;
            st_mtd[i]   = 1'($urandom_range(0, 1));
            st_rdy[i]   = 1'($urandom_range(0, 1));
            st_len[i]   = 5'($urandom_range(0, 31));
            st_pas[i]   = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic busy_row(input int t, input int p);
        ex[t].ready = 1'b0;
        ex[t].busy  = 1'b1;
        ex[t].pidx  = p;
    endtask

    // wfix: REDUCE cycles before MTreeDone (-1 random); rmode: 0 always ready, 1 random, 2 stall on writes 2-3 of pass 0
    // cut: 0 none, 1 abort in DRAIN of pass 1, 2 reset in WRITE of pass 0, 3 abort at a random busy cycle
    task automatic build(input int len, input int npass, input int wfix, input int rmode, input int cut);
        int t, k, w, wc, lastp, td1, tw0, tc;
        bit r;
        clear_sched();
        lastp = (npass == 0) ? 0 : npass - 1;
        td1 = 1;
        tw0 = 1;
        st_start[0] = 1'b1;
        st_len[0] = 5'(len);
        st_pas[0] = 3'(npass);
        t = 1;
        for (int p = 0; p <= lastp; p++) begin
            for (int i = 0; i < len; i++) begin
                busy_row(t, p);
                ex[t].ena = 1'b1;
                ex[t].addra = i;
                ex[t].mpe = 1'b1;
                ex[t + PD + 1].cie = 1'b1;
                t++;
            end
            if (p == 1) td1 = t;
            for (int i = 0; i <= PD; i++) begin
                busy_row(t, p);
                ex[t].mpe = 1'b1;
                t++;
            end
            w = (wfix >= 0) ? wfix : int'($urandom_range(0, 6));
            for (int j = 0; j <= w; j++) begin
                busy_row(t, p);
                ex[t].trig = (j < NB);
                st_mtd[t] = (j == w);
                t++;
            end
            if (p == 0) tw0 = t;
            k = 0;
            wc = 0;
            while (k < BS) begin
                r = (rmode == 0) ? 1'b1 :
                    (rmode == 2) ? !(p == 0 && (wc == 2 || wc == 3)) : ($urandom_range(0, 3) != 0);
                st_rdy[t] = r;
                busy_row(t, p);
                ex[t].enb = r;
                ex[t].addrb = p * BS + k;
                if (r) k++;
                wc++;
                t++;
            end
        end
        ex[t].ready = 1'b0;
        ex[t].done = 1'b1;
        ex[t].pidx = lastp;
        for (int i = 1; i <= t; i++) st_start[i] = ($urandom_range(0, 3) == 0);
        n_cyc = t + 2;
        if (cut != 0) begin
            tc = (cut == 1) ? td1 + 1 : (cut == 2) ? tw0 + 2 : int'($urandom_range(1, t - 1));
            if (cut == 2) st_rst[tc] = 1'b1;
            else          st_abort[tc] = 1'b1;
            for (int i = tc + 1; i < N; i++) begin
                ex[i] = idle_ex;
                st_start[i] = 1'b0;
                st_rdy[i] = 1'b1;
            end
            n_cyc = tc + 4;
        end
    endtask

    task automatic build_err(input int len, input int npass, input bit with_abort);
        clear_sched();
        st_start[0] = 1'b1;
        st_abort[0] = with_abort;
        st_len[0] = 5'(len);
        st_pas[0] = 3'(npass);
        ex[1].err = !with_abort;
        n_cyc = 3;
    endtask

    task automatic run(input string name);
        for (int t = 0; t < n_cyc; t++) begin
            @(negedge clk);
            Start     = st_start[t];
            Abort     = st_abort[t];
            rst       = st_rst[t];
            MTreeDone = st_mtd[t];
            WrReady   = st_rdy[t];
            CfgLen    = st_len[t];
            CfgPasses = st_pas[t];
            #1;
            check($sformatf("%s@%0d", name, t), 64'(dut_vec()), 64'(pk(ex[t])));
        end
    endtask

    initial begin
        idle_ex = '{default: 0};
        idle_ex.ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset", 64'(dut_vec()), 64'(pk(idle_ex)));
        build(10, 1, 5, 0, 0);  run("nominal");
        build(6, 3, -1, 0, 0);  run("multipass");
        build(10, 1, 2, 2, 0);  run("backpressure");
        build(5, 3, -1, 1, 1);  run("abort_drain");
        build(7, 2, -1, 1, 0);  run("after_abort");
        build_err(0, 1, 0);     run("cfg_len0");
        build_err(17, 1, 0);    run("cfg_len17");
        build_err(5, 5, 0);     run("cfg_passes5");
        build_err(5, 2, 1);     run("start_abort_idle");
        build(4, 2, -1, 1, 2);  run("reset_write");
        build(3, 0, 0, 1, 0);   run("passes0");
        build(16, 4, -1, 1, 0); run("maxcfg");
        for (int i = 0; i < 25; i++) begin
            build(int'($urandom_range(1, ML)), int'($urandom_range(0, MP)), -1, 1,
                  ($urandom_range(0, 4) == 0) ? 3 : 0);
            run($sformatf("rand%0d", i));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
